// File: rtl/spi_flash_pkg.sv
// Shared types and command codes for the SPI boot-flash responder.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    STAT,
    ID,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  function automatic state_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_READ: return ADDR;
      CMD_RDSR: return STAT;
      CMD_RDID: return ID;
      default:  return IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a history flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    // NOTE: reset preloads the live pin level so no phantom edge appears when
    // reset releases while the pin is already low (e.g. cs_n held mid-transfer).
    if (reset) sync_q <= {3{pin}};
    else       sync_q <= {sync_q[1:0], pin};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a boot flash: READ (0x03), RDSR (0x05) and
// RDID (0x9F), served from an external ROM with one cycle of read latency.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter int          ROM_AW   = 12,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd_en,
  output logic [ROM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(ADDR_W);

  logic cs_level_unused, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .pin   (spi_cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .pin   (spi_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_pin_sync u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .pin   (spi_mosi),
    .level (mosi),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_sr;
  logic [ROM_AW-2:0] addr_sr;
  logic [ROM_AW-1:0] addr;
  logic [7:0]        tx_sr;
  logic [7:0]        nxt_byte;
  logic [1:0]        id_cnt;
  logic              rd_pend;
  logic [7:0]        resp_byte;

  // Byte to start shifting out on the first falling edge of each response byte.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missed branch would otherwise infer a latch.
    resp_byte = 8'h00;
    case (state)
      DATA: resp_byte = nxt_byte;
      ID: begin
        case (id_cnt)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          2'd2:    resp_byte = JEDEC_ID[7:0];
          default: resp_byte = 8'h00;
        endcase
      end
      default: resp_byte = 8'h00;
    endcase
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      addr      <= '0;
      tx_sr     <= '0;
      nxt_byte  <= '0;
      id_cnt    <= '0;
      rd_pend   <= 1'b0;
      spi_miso  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      rd_pend   <= mem_rd_en;
      if (rd_pend) nxt_byte <= mem_rdata;

      // Deselect takes priority over any sclk edge seen in the same cycle.
      if (state != IDLE && cs_rise) begin
        state    <= IDLE;
        busy     <= 1'b0;
        spi_miso <= 1'b0;
        bit_cnt  <= '0;
        cmd_sr   <= '0;
        addr_sr  <= '0;
        tx_sr    <= '0;
        id_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (cs_fall) begin
              state    <= CMD;
              busy     <= 1'b1;
              spi_miso <= 1'b0;
              bit_cnt  <= '0;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              cmd_sr <= {cmd_sr[5:0], mosi};
              if (bit_cnt == CNT_W'(7)) begin
                state   <= decode_cmd({cmd_sr, mosi});
                bit_cnt <= '0;
                id_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          // Only the low ROM_AW address bits survive the shift register.
          ADDR: begin
            if (sclk_rise) begin
              addr_sr <= {addr_sr[ROM_AW-3:0], mosi};
              if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                addr      <= {addr_sr, mosi};
                mem_addr  <= {addr_sr, mosi};
                mem_rd_en <= 1'b1;
                state     <= DATA;
                bit_cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          DATA, STAT, ID: begin
            if (sclk_fall) begin
              if (bit_cnt[2:0] == 3'd0) begin
                spi_miso <= resp_byte[7];
                tx_sr    <= {resp_byte[6:0], 1'b0};
                if (state == ID && id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
              end else begin
                spi_miso <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b0};
              end
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (sclk_rise && state == DATA && bit_cnt[2:0] == 3'd4) begin
              // Mid-byte prefetch leaves the next byte ready well before its first fall.
              addr      <= addr + ROM_AW'(1);
              mem_addr  <= addr + ROM_AW'(1);
              mem_rd_en <= 1'b1;
            end
          end

          IGNORE: spi_miso <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
